// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receives asynchronous-style serial frames on a single line whose bit
//   timing is given by an external strobe. A frame is one start bit (0),
//   DATA_W data bits sent LSB first, an optional even-parity bit, and one
//   stop bit (1). Good frames are presented on data_out with a
//   valid/ready handshake. Bad frames and dropped frames are reported
//   with one-cycle pulses.
//
//   Compile-time option: define PARITY_CHECK_EN to expect and check an
//   even-parity bit after the data bits. Without it the frame has no
//   parity bit, and parity_err is held at 0.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   bit_en     : bit strobe; serial_in is sampled only when it is 1
//   serial_in  : serial line, idles at 1
//   data_out   : payload of the last accepted frame
//   data_valid : data_out holds a frame the consumer has not taken yet
//   data_ready : consumer accepts data_out
//   frame_err  : one-cycle pulse, stop bit was 0
//   parity_err : one-cycle pulse, parity mismatch (PARITY_CHECK_EN only)
//   overrun    : one-cycle pulse, good frame dropped because data_valid was 1
//
// Handshake: a transfer happens on every rising clk edge where
// data_valid=1 and data_ready=1. data_out is stable while data_valid=1.
// data_valid stays high without a transfer. A new frame that arrives on
// the same edge as a transfer replaces the old one, and data_valid stays 1.

module serial_frame_receiver #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              frame_err_q;
  logic              overrun_q;
`ifdef PARITY_CHECK_EN
  logic              par_bad_q;
  logic              parity_err_q;
`endif

  // Data bits arrive LSB first, so shift new bits in from the top.
  assign shreg_d = {serial_in, shreg_q[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
      // Consumption. A delivery later in this block overrides this clear.
      if (data_valid_q && data_ready) data_valid_q <= 1'b0;

      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!serial_in) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            // Even parity: XOR of the data bits and the parity bit must be 0.
            par_bad_q <= (^shreg_q) ^ serial_in;
            state_q   <= STOP;
          end
`endif
          STOP: begin
            // A 0 stop bit is not taken as a new start bit. The FSM always
            // returns to IDLE and waits for a fresh falling bit.
            state_q <= IDLE;
`ifdef PARITY_CHECK_EN
            if (par_bad_q) begin
              parity_err_q <= 1'b1;
            end else
`endif
            if (!serial_in) begin
              frame_err_q <= 1'b1;
            end else if (data_valid_q && !data_ready) begin
              overrun_q <= 1'b1;
            end else begin
              data_out_q   <= shreg_q;
              data_valid_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_en = 1'b0;
  logic         serial_in = 1'b1;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  logic ready_at_stop = 1'b0;
`ifdef PARITY_CHECK_EN
  logic bad_par = 1'b0;
`endif

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_frame_receiver #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .serial_in (serial_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge. Inputs change just after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      fe_cnt += int'(frame_err);
      pe_cnt += int'(parity_err);
      ov_cnt += int'(overrun);
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_data: got %0h expected none", data_out);
        end else begin
          check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int period);
    repeat (period - 1) begin
      tick();
      bit_en = 1'b0;
    end
    tick();
    serial_in = b;
    bit_en = 1'b1;
  endtask

  // Returns just after the edge that sampled the stop bit.
  task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input int period);
    send_bit(1'b0, period);
    for (int i = 0; i < W; i++) send_bit(d[i], period);
`ifdef PARITY_CHECK_EN
    send_bit((^d) ^ bad_par, period);
`endif
    send_bit(stop_b, period);
    data_ready = ready_at_stop;
    tick();
    bit_en = 1'b0;
    serial_in = 1'b1;
    data_ready = 1'b0;
  endtask

  task automatic consume();
    tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    int p;
    int exp_pe;
    exp_pe = 0;

    // reset state
    repeat (3) tick();
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // basic frame, delivered one edge after the stop bit and held
    exp_q.push_back(8'h4A);
    send_frame(8'h4A, 1'b1, 1);
    check("f4a_valid", 32'(data_valid), 32'd1);
    check("f4a_data", 32'(data_out), 32'h4A);
    check("f4a_ferr", 32'(frame_err), 32'd0);
    tick();
    tick();
    check("f4a_hold", 32'(data_valid), 32'd1);
    check("f4a_hold_data", 32'(data_out), 32'h4A);
    consume();
    check("f4a_cleared", 32'(data_valid), 32'd0);

    // bad stop bit, then a good frame right after
    send_frame(8'h4A, 1'b0, 1);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    check("ferr_valid", 32'(data_valid), 32'd0);
    tick();
    check("ferr_gone", 32'(frame_err), 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1);
    check("fa5_valid", 32'(data_valid), 32'd1);
    check("fa5_data", 32'(data_out), 32'hA5);
    consume();

    // overrun: second frame dropped while first is pending
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_keep", 32'(data_out), 32'h11);
    check("ovr_valid", 32'(data_valid), 32'd1);
    tick();
    check("ovr_gone", 32'(overrun), 32'd0);
    consume();

    // delivery coincides with consumption
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1);
    exp_q.push_back(8'h33);
    ready_at_stop = 1'b1;
    send_frame(8'h33, 1'b1, 1);
    ready_at_stop = 1'b0;
    check("co_valid", 32'(data_valid), 32'd1);
    check("co_data", 32'(data_out), 32'h33);
    check("co_ovr", 32'(overrun), 32'd0);
    consume();

    // reset mid-frame with a pending frame, strobe every 4th cycle
    send_frame(8'h5C, 1'b1, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    tick();
    rst = 1'b1;
    bit_en = 1'b1;
    serial_in = 1'b0;
    data_ready = 1'b1;
    tick();
    rst = 1'b0;
    bit_en = 1'b0;
    serial_in = 1'b1;
    data_ready = 1'b0;
    check("mrst_valid", 32'(data_valid), 32'd0);
    check("mrst_data", 32'(data_out), 32'd0);
    check("mrst_ferr", 32'(frame_err), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 4);
    check("fc3_valid", 32'(data_valid), 32'd1);
    check("fc3_data", 32'(data_out), 32'hC3);
    consume();

    // random frames and bit periods
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom_range(0, 255));
      p = $urandom_range(1, 3);
      exp_q.push_back(d);
      send_frame(d, 1'b1, p);
      check("rnd_valid", 32'(data_valid), 32'd1);
      consume();
    end

`ifdef PARITY_CHECK_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1);
    check("par_ok_valid", 32'(data_valid), 32'd1);
    check("par_ok_data", 32'(data_out), 32'h07);
    consume();
    bad_par = 1'b1;
    send_frame(8'h07, 1'b0, 1);
    bad_par = 1'b0;
    exp_pe = 1;
    check("par_pulse", 32'(parity_err), 32'd1);
    check("par_no_ferr", 32'(frame_err), 32'd0);
    check("par_valid", 32'(data_valid), 32'd0);
    tick();
    check("par_gone", 32'(parity_err), 32'd0);
`endif

    repeat (3) tick();
    check("sb_left", 32'(exp_q.size()), 32'd0);
    check("ferr_count", 32'(fe_cnt), 32'd1);
    check("ovr_count", 32'(ov_cnt), 32'd1);
    check("perr_count", 32'(pe_cnt), 32'(exp_pe));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
